config_chain_loader: RTL and testbench



---
 rtl/cgra_cfg_pkg.sv | 23 ++
 rtl/cfg_shift_word.sv | 64 ++++++
 rtl/config_chain_loader.sv | 157 +++++++++++++++
 tb/tb_config_chain_loader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the CGRA configuration-chain loader.
//   loader_state_t : sequencer states (IDLE, CLEAR, FETCH, SHIFT, DONE)
//   cnt_w()        : bit width of a counter that must hold 0..max_val inclusive
//   *_CHAIN_LEN    : default scan-chain lengths per PE block type
package cgra_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    SHIFT,
    DONE
  } loader_state_t;

  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned BLOCKPE_CHAIN_LEN     = 64;
  localparam int unsigned FULLYCONN_CHAIN_LEN   = 40;
  localparam int unsigned CONFIG_CELL_CHAIN_LEN = 8;

endpackage

// File: rtl/cfg_shift_word.sv
// One-word serialiser/deserialiser for the configuration chain.
//   clk, reset : clock, asynchronous active-high reset
//   load_i     : latch word_i into the shift register, clear readback, bit_idx=0
//   word_i     : bitstream word to serialise
//   shift_i    : shift one bit out (LSB first) and capture ser_i at bit_idx
//   ser_i      : chain config_out
//   ser_o      : current bit toward chain config_in (flop output)
//   rb_word_o  : bits captured so far; bits not yet shifted read as zero
//   bit_idx_o  : number of bits shifted since the last load
module cfg_shift_word
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned IDX_W  = cnt_w(WORD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              shift_i,
  input  logic              ser_i,
  output logic              ser_o,
  output logic [WORD_W-1:0] rb_word_o,
  output logic [IDX_W-1:0]  bit_idx_o
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] rb_shreg_q, rb_shreg_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;

  always_comb begin
    shreg_d    = shreg_q;
    rb_shreg_d = rb_shreg_q;
    bit_idx_d  = bit_idx_q;
    if (load_i) begin
      shreg_d    = word_i;
      rb_shreg_d = '0;
      bit_idx_d  = '0;
    end else if (shift_i) begin
      shreg_d = shreg_q >> 1;
      for (int unsigned i = 0; i < WORD_W; i++) begin
        if (bit_idx_q == IDX_W'(i)) rb_shreg_d[i] = ser_i;
      end
      bit_idx_d = bit_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q    <= '0;
      rb_shreg_q <= '0;
      bit_idx_q  <= '0;
    end else begin
      shreg_q    <= shreg_d;
      rb_shreg_q <= rb_shreg_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

  assign ser_o     = shreg_q[0];
  assign rb_word_o = rb_shreg_q;
  assign bit_idx_o = bit_idx_q;

endmodule

// File: rtl/config_chain_loader.sv
// Sequencer that clears a PE configuration scan chain, shifts CHAIN_LEN bits
// from a word-wide bitstream into it (word bit 0 first) and returns the
// chain's previous contents word by word.
//   clk, reset   : clock, asynchronous active-high reset
//   start        : begin a load (sampled only while idle)
//   abort        : cancel an in-progress load
//   word_in/word_valid/word_ready : bitstream word handshake
//   cfg_reset_o  : chain config_reset
//   cfg_shift_en : enable for the gated chain config_clk
//   cfg_data_o   : chain config_in
//   cfg_data_i   : chain config_out
//   rb_word/rb_valid : readback word and its one-cycle strobe
//   busy, done   : not idle / one-cycle completion strobe
module config_chain_loader
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN  = BLOCKPE_CHAIN_LEN,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_reset_o,
  output logic              cfg_shift_en,
  output logic              cfg_data_o,
  input  logic              cfg_data_i,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BL_W  = cnt_w(CHAIN_LEN);
  localparam int unsigned CC_W  = cnt_w(CLR_CYCLES);
  localparam int unsigned IDX_W = cnt_w(WORD_W);

  loader_state_t   state_q, state_d;
  logic [BL_W-1:0] bits_left_q, bits_left_d;
  logic [CC_W-1:0] clr_cnt_q, clr_cnt_d;
  logic word_ready_q, word_ready_d;
  logic cfg_reset_q, cfg_reset_d;
  logic shift_en_q, shift_en_d;
  logic rb_valid_q, rb_valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic             load_word, shift_bit, word_end;
  logic [IDX_W-1:0] bit_idx;

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    clr_cnt_d   = clr_cnt_q;
    load_word   = 1'b0;
    shift_bit   = 1'b0;
    rb_valid_d  = 1'b0;
    word_end    = (bit_idx == IDX_W'(WORD_W - 1)) || (bits_left_q == BL_W'(1));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = CLEAR;
          clr_cnt_d   = CC_W'(CLR_CYCLES);
          bits_left_d = BL_W'(CHAIN_LEN);
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q - CC_W'(1);
        if (clr_cnt_q == CC_W'(1)) state_d = FETCH;
      end
      FETCH: begin
        if (word_valid && word_ready_q) begin
          load_word = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_bit   = 1'b1;
        bits_left_d = bits_left_q - BL_W'(1);
        if (word_end) begin
          rb_valid_d = 1'b1;
          state_d    = (bits_left_q == BL_W'(1)) ? DONE : FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a same-cycle word handshake.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      load_word  = 1'b0;
      shift_bit  = 1'b0;
      rb_valid_d = 1'b0;
    end

    // Outputs are registered decodes of the next state so the chain sees
    // glitch-free enables that track the state register exactly.
    word_ready_d = (state_d == FETCH);
    cfg_reset_d  = (state_d == CLEAR);
    shift_en_d   = (state_d == SHIFT);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bits_left_q  <= '0;
      clr_cnt_q    <= '0;
      word_ready_q <= 1'b0;
      cfg_reset_q  <= 1'b0;
      shift_en_q   <= 1'b0;
      rb_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bits_left_q  <= bits_left_d;
      clr_cnt_q    <= clr_cnt_d;
      word_ready_q <= word_ready_d;
      cfg_reset_q  <= cfg_reset_d;
      shift_en_q   <= shift_en_d;
      rb_valid_q   <= rb_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  cfg_shift_word #(
    .WORD_W(WORD_W),
    .IDX_W (IDX_W)
  ) u_shift_word (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load_word),
    .word_i   (word_in),
    .shift_i  (shift_bit),
    .ser_i    (cfg_data_i),
    .ser_o    (cfg_data_o),
    .rb_word_o(rb_word),
    .bit_idx_o(bit_idx)
  );

  assign word_ready   = word_ready_q;
  assign cfg_reset_o  = cfg_reset_q;
  assign cfg_shift_en = shift_en_q;
  assign rb_valid     = rb_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Self-checking bench for config_chain_loader with a 40-bit chain and 32-bit
// words. A behavioural scan-chain model feeds cfg_data_i; expectations come
// from the bit-order rules applied to the offered words and chain preload.
module tb_config_chain_loader;

  localparam int unsigned CHAIN_LEN  = 40;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned CLR_CYCLES = 2;
  localparam int unsigned NWORDS     = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic clk = 1'b0;
  logic reset, start, abort, word_valid, word_ready;
  logic cfg_reset_o, cfg_shift_en, cfg_data_o, cfg_data_i;
  logic rb_valid, busy, done;
  logic [WORD_W-1:0] word_in, rb_word;

  always #5 clk = ~clk;

  config_chain_loader #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W),
    .CLR_CYCLES(CLR_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .cfg_reset_o (cfg_reset_o),
    .cfg_shift_en(cfg_shift_en),
    .cfg_data_o  (cfg_data_o),
    .cfg_data_i  (cfg_data_i),
    .rb_word     (rb_word),
    .rb_valid    (rb_valid),
    .busy        (busy),
    .done        (done)
  );

  // Scan chain: config_out is bit 0, config_in enters at the top.
  logic [CHAIN_LEN-1:0] chain, preload_val;
  logic                 preload_req;
  assign cfg_data_i = chain[0];
  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (cfg_shift_en) chain <= {cfg_data_o, chain[CHAIN_LEN-1:1]};
  end

  int n_checks, n_pass, cyc;
  int shift_cnt, done_cnt, rst_cnt, overlap_cnt, busy_cnt, first_rst, first_rdy;
  bit data_bits[$];
  logic [WORD_W-1:0] rb_q[$];
  logic [WORD_W-1:0] src_q[$];
  logic [WORD_W-1:0] words[NWORDS];
  bit hold_valid, jitter;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_stats();
    shift_cnt = 0; done_cnt = 0; rst_cnt = 0; overlap_cnt = 0; busy_cnt = 0;
    first_rst = -1; first_rdy = -1;
    data_bits.delete();
    rb_q.delete();
  endtask

  // Advance one cycle: retire a handshake that happened at the edge, present
  // the next source word, then record the outputs of the new cycle.
  task automatic step();
    bit hs;
    hs = (word_valid === 1'b1) && (word_ready === 1'b1) && (abort !== 1'b1) && (reset !== 1'b1);
    @(negedge clk);
    cyc++;
    start = 1'b0;
    abort = 1'b0;
    if (hs && src_q.size() > 0) void'(src_q.pop_front());
    word_valid = (src_q.size() > 0) && !hold_valid && !(jitter && ($urandom_range(0, 2) == 0));
    word_in    = (src_q.size() > 0) ? src_q[0] : '0;
    if (cfg_shift_en === 1'b1) begin
      shift_cnt++;
      data_bits.push_back(cfg_data_o);
    end
    if (cfg_reset_o === 1'b1) begin
      rst_cnt++;
      if (first_rst < 0) first_rst = cyc;
    end
    if (word_ready === 1'b1 && first_rdy < 0) first_rdy = cyc;
    if (cfg_reset_o === 1'b1 && cfg_shift_en === 1'b1) overlap_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (rb_valid === 1'b1) rb_q.push_back(rb_word);
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic do_preload(input logic [CHAIN_LEN-1:0] pre);
    preload_val = pre;
    preload_req = 1'b1;
    step();
    preload_req = 1'b0;
  endtask

  // Chain image after a load: bit j comes from word j/WORD_W, bit j%WORD_W.
  function automatic logic [CHAIN_LEN-1:0] exp_chain();
    logic [CHAIN_LEN-1:0] r;
    logic [WORD_W-1:0] w;
    for (int unsigned j = 0; j < CHAIN_LEN; j++) begin
      w = words[j / WORD_W];
      r[j] = w[j % WORD_W];
    end
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] exp_rb(input logic [CHAIN_LEN-1:0] pre, input int unsigned i);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < WORD_W; b++)
      if (i * WORD_W + b < CHAIN_LEN) r[b] = pre[i * WORD_W + b];
    return r;
  endfunction

  function automatic logic [CHAIN_LEN-1:0] packed_stream();
    logic [CHAIN_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < data_bits.size() && i < CHAIN_LEN; i++) r[i] = data_bits[i];
    return r;
  endfunction

  function automatic logic [CHAIN_LEN-1:0] rand_chain();
    return CHAIN_LEN'({$urandom(), $urandom()});
  endfunction

  task automatic load_and_check(input string tag, input logic [CHAIN_LEN-1:0] pre,
                                input bit jit, input bit start_mid, input bit hold);
    int t0, n, rdy_low;
    bit pulsed;
    do_preload(pre);
    clear_stats();
    jitter     = jit;
    hold_valid = hold;
    for (int i = 0; i < NWORDS; i++) src_q.push_back(words[i]);
    step();
    start = 1'b1;
    t0 = cyc;
    if (hold) begin
      n = 0;
      do begin step(); n++; end while (word_ready !== 1'b1 && n < 20);
      rdy_low = 0;
      repeat (10) begin
        step();
        if (word_ready !== 1'b1) rdy_low++;
      end
      check({tag, ".hold_ready"}, 64'(rdy_low), 64'(0));
      check({tag, ".hold_no_shift"}, 64'(shift_cnt), 64'(0));
      hold_valid = 1'b0;
    end
    n = 0;
    pulsed = 1'b0;
    do begin
      step();
      n++;
      if (start_mid && !pulsed && shift_cnt == 10) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
    end while (busy === 1'b1 && n < 400);
    jitter = 1'b0;
    repeat (3) step();
    check({tag, ".finished"}, 64'(busy), 64'(0));
    check({tag, ".shift_cnt"}, 64'(shift_cnt), 64'(CHAIN_LEN));
    check({tag, ".stream"}, 64'(packed_stream()), 64'(exp_chain()));
    check({tag, ".done_cnt"}, 64'(done_cnt), 64'(1));
    check({tag, ".rb_cnt"}, 64'(rb_q.size()), 64'(NWORDS));
    for (int unsigned i = 0; i < NWORDS; i++)
      if (i < rb_q.size()) check($sformatf("%s.rb%0d", tag, i), 64'(rb_q[i]), 64'(exp_rb(pre, i)));
    check({tag, ".chain"}, 64'(chain), 64'(exp_chain()));
    check({tag, ".clr_cycles"}, 64'(rst_cnt), 64'(CLR_CYCLES));
    check({tag, ".no_overlap"}, 64'(overlap_cnt), 64'(0));
    if (!jit) begin
      check({tag, ".first_clr"}, 64'(first_rst), 64'(t0 + 1));
      check({tag, ".first_ready"}, 64'(first_rdy), 64'(t0 + CLR_CYCLES + 1));
      if (!hold)
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(CLR_CYCLES + NWORDS + CHAIN_LEN + 1));
    end
  endtask

  initial begin
    int n;
    n_checks = 0; n_pass = 0; cyc = 0;
    preload_req = 1'b0; preload_val = '0;
    hold_valid = 1'b0; jitter = 1'b0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_in = '0;
    clear_stats();

    // Reset state
    #12;
    check("reset.ctrl", 64'({word_ready, cfg_reset_o, cfg_shift_en, cfg_data_o, rb_valid, busy, done}), 64'(0));
    check("reset.rb_word", 64'(rb_word), 64'(0));
    step(); step();
    reset = 1'b0;
    step(); step();
    check("reset.idle_after", 64'({busy, word_ready, cfg_reset_o}), 64'(0));

    // Directed two-word load with explicit bit stream
    words[0] = 32'h0000_0005;
    words[1] = 32'h0000_00A3;
    load_and_check("plan_a", rand_chain(), 1'b0, 1'b0, 1'b0);
    check("plan_a.literal_stream", 64'(packed_stream()), 64'h00_A3_0000_0005);

    // Readback of a known chain image with all-zero words
    words[0] = '0;
    words[1] = '0;
    load_and_check("plan_b", 40'h12_DEAD_BEEF, 1'b0, 1'b0, 1'b0);
    if (rb_q.size() == 2) begin
      check("plan_b.rb0_literal", 64'(rb_q[0]), 64'hDEAD_BEEF);
      check("plan_b.rb1_literal", 64'(rb_q[1]), 64'h12);
    end
    check("plan_b.chain_zero", 64'(chain), 64'(0));

    // Randomised loads with irregular word_valid
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NWORDS; i++) words[i] = $urandom();
      load_and_check($sformatf("rand%0d", k), rand_chain(), 1'b1, 1'b0, 1'b0);
    end

    // word_valid withheld in FETCH for 10 cycles
    for (int i = 0; i < NWORDS; i++) words[i] = $urandom();
    load_and_check("hold", rand_chain(), 1'b0, 1'b0, 1'b1);

    // Abort on the 5th shift cycle of word 0
    for (int i = 0; i < NWORDS; i++) words[i] = $urandom();
    do_preload(rand_chain());
    clear_stats();
    for (int i = 0; i < NWORDS; i++) src_q.push_back(words[i]);
    step();
    start = 1'b1;
    n = 0;
    do begin step(); n++; end while (shift_cnt < 5 && n < 50);
    check("abort.reach", 64'(shift_cnt), 64'(5));
    abort = 1'b1;
    step();
    check("abort.idle_next", 64'({busy, cfg_shift_en, cfg_reset_o, word_ready}), 64'(0));
    src_q.delete();
    repeat (3) step();
    check("abort.shift_total", 64'(shift_cnt), 64'(5));
    check("abort.no_done", 64'(done_cnt), 64'(0));
    check("abort.no_rb", 64'(rb_q.size()), 64'(0));
    for (int i = 0; i < NWORDS; i++) words[i] = $urandom();
    load_and_check("after_abort", rand_chain(), 1'b0, 1'b0, 1'b0);

    // start pulsed during SHIFT is ignored
    for (int i = 0; i < NWORDS; i++) words[i] = $urandom();
    load_and_check("start_mid", rand_chain(), 1'b0, 1'b1, 1'b0);

    // start and abort together in CLEAR
    clear_stats();
    step();
    start = 1'b1;
    step();
    check("clr_abort.in_clear", 64'(cfg_reset_o), 64'(1));
    start = 1'b1;
    abort = 1'b1;
    step();
    check("clr_abort.idle", 64'({busy, cfg_reset_o, word_ready}), 64'(0));
    step();
    check("clr_abort.stays_idle", 64'(busy), 64'(0));

    // Asynchronous reset between edges mid-SHIFT
    for (int i = 0; i < NWORDS; i++) words[i] = $urandom();
    clear_stats();
    for (int i = 0; i < NWORDS; i++) src_q.push_back(words[i]);
    step();
    start = 1'b1;
    n = 0;
    do begin step(); n++; end while (shift_cnt < 3 && n < 50);
    check("async_rst.in_shift", 64'(cfg_shift_en), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("async_rst.ctrl", 64'({word_ready, cfg_reset_o, cfg_shift_en, cfg_data_o, rb_valid, busy, done}), 64'(0));
    check("async_rst.rb_word", 64'(rb_word), 64'(0));
    src_q.delete();
    step(); step();
    reset = 1'b0;
    step();
    check("async_rst.no_done", 64'(done_cnt), 64'(0));
    check("async_rst.idle", 64'(busy), 64'(0));

    for (int i = 0; i < NWORDS; i++) words[i] = $urandom();
    load_and_check("post_reset", rand_chain(), 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
